// File: rtl/cmos_lane_driver.sv
// Host-side sequencer for the dual-rail CMOS evaluation lane: spacer phase, evaluation phase,
// double sample of the lane result with a stability check, and a valid/ready result return.
module cmos_lane_driver #(
    parameter int BIT_SIZE      = 64,
    parameter int SPACER_CYCLES = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BIT_SIZE-1:0] in_x,
    input  logic [BIT_SIZE-1:0] in_k,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BIT_SIZE-1:0] out_s,
    output logic                out_unstable,
    output logic [BIT_SIZE-1:0] x_top,
    output logic [BIT_SIZE-1:0] x_bar_top,
    output logic [BIT_SIZE-1:0] k_top,
    output logic [BIT_SIZE-1:0] k_bar_top,
    input  logic [BIT_SIZE-1:0] s_top,
    output logic                busy,
    output logic [15:0]         err_count
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SPACER   = 3'd1;
    localparam logic [2:0] S_EVAL     = 3'd2;
    localparam logic [2:0] S_SAMPLE_A = 3'd3;
    localparam logic [2:0] S_SAMPLE_B = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam logic [CNT_W-1:0] SPACER_LOAD = CNT_W'(SPACER_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    logic [2:0]          state;
    logic [2:0]          state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [BIT_SIZE-1:0] x_reg;
    logic [BIT_SIZE-1:0] k_reg;
    logic [BIT_SIZE-1:0] samp_a;
    logic                accept;
    logic                rails_on_nxt;
    logic                unstable_now;

    assign in_ready     = (state == S_IDLE);
    assign busy         = (state != S_IDLE);
    assign accept       = in_valid & in_ready;
    assign unstable_now = (samp_a != s_top);

    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_SPACER;
                    cnt_nxt   = SPACER_LOAD;
                end
            end
            S_SPACER: begin
                if (cnt == '0) begin
                    state_nxt = S_EVAL;
                    cnt_nxt   = SETTLE_LOAD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_EVAL: begin
                if (cnt == '0) state_nxt = S_SAMPLE_A;
                else           cnt_nxt   = cnt - 1'b1;
            end
            S_SAMPLE_A: state_nxt = S_SAMPLE_B;
            S_SAMPLE_B: state_nxt = S_DONE;
            S_DONE: begin
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Rails are registered off the next state so they switch on the same edge as the FSM.
    assign rails_on_nxt = (state_nxt == S_EVAL) || (state_nxt == S_SAMPLE_A) ||
                          (state_nxt == S_SAMPLE_B);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            x_reg        <= '0;
            k_reg        <= '0;
            samp_a       <= '0;
            x_top        <= '0;
            x_bar_top    <= '0;
            k_top        <= '0;
            k_bar_top    <= '0;
            out_valid    <= 1'b0;
            out_s        <= '0;
            out_unstable <= 1'b0;
            err_count    <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            out_valid <= (state_nxt == S_DONE);
            if (accept) begin
                x_reg <= in_x;
                k_reg <= in_k;
            end
            if (rails_on_nxt) begin
                x_top     <= x_reg;
                x_bar_top <= ~x_reg;
                k_top     <= k_reg;
                k_bar_top <= ~k_reg;
            end else begin
                x_top     <= '0;
                x_bar_top <= '0;
                k_top     <= '0;
                k_bar_top <= '0;
            end
            if (state == S_SAMPLE_A) samp_a <= s_top;
            if (state == S_SAMPLE_B) begin
                out_s        <= s_top;
                out_unstable <= unstable_now;
                if (unstable_now && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cmos_lane_driver.sv
// Directed bench for cmos_lane_driver: default build against a 2-cycle XOR lane model,
// plus a SPACER=1/SETTLE=1 build against a combinational XOR lane.
module tb_cmos_lane_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_unstable, busy;
    logic [63:0] in_x, in_k, out_s, x_top, x_bar_top, k_top, k_bar_top, s_top;
    logic [15:0] err_count;

    logic        in2_valid, in2_ready, out2_valid, out2_ready, out2_unstable, busy2;
    logic [63:0] in2_x, in2_k, out2_s, x2_top, x2_bar_top, k2_top, k2_bar_top, s2_top;
    logic [15:0] err2_count;

    logic [63:0] lane_p1, lane_p2;
    logic        tog;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cmos_lane_driver dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_k(in_k), .out_valid(out_valid), .out_ready(out_ready),
        .out_s(out_s), .out_unstable(out_unstable), .x_top(x_top), .x_bar_top(x_bar_top),
        .k_top(k_top), .k_bar_top(k_bar_top), .s_top(s_top), .busy(busy), .err_count(err_count)
    );

    cmos_lane_driver #(.SPACER_CYCLES(1), .SETTLE_CYCLES(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in2_valid), .in_ready(in2_ready),
        .in_x(in2_x), .in_k(in2_k), .out_valid(out2_valid), .out_ready(out2_ready),
        .out_s(out2_s), .out_unstable(out2_unstable), .x_top(x2_top), .x_bar_top(x2_bar_top),
        .k_top(k2_top), .k_bar_top(k2_bar_top), .s_top(s2_top), .busy(busy2), .err_count(err2_count)
    );

    // Lane model: s = x ^ k two clocks after the rails, with an optional bit-0 disturbance.
    always_ff @(posedge clk) begin
        lane_p1 <= x_top ^ k_top;
        lane_p2 <= lane_p1;
    end
    assign s_top  = lane_p2 ^ {63'd0, tog};
    assign s2_top = x2_top ^ k2_top;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_unstable(input logic [63:0] x, input logic [63:0] k, input logic [15:0] exp_err);
        in_x = x; in_k = k; in_valid = 1'b1;
        tick();                          // accept edge; now in cycle 1
        in_valid = 1'b0;
        repeat (7) tick();               // cycle 8: SAMPLE_B, after samp_a was taken
        tog = 1'b1;
        tick();                          // cycle 9: DONE
        check("unst_valid", 64'(out_valid), 64'd1);
        check("unst_flag", 64'(out_unstable), 64'd1);
        check("unst_s", out_s, (x ^ k) ^ 64'd1);
        check("unst_err", 64'(err_count), 64'(exp_err));
        tog = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    localparam logic [63:0] X1 = 64'hFFFF_FFFF_0000_0000;
    localparam logic [63:0] K1 = 64'h0123_4567_89AB_CDEF;

    initial begin
        logic [63:0] hold_s;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_x = '0; in_k = '0; tog = 1'b0;
        in2_valid = 1'b0; out2_ready = 1'b0; in2_x = '0; in2_k = '0;
        #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_err", 64'(err_count), 64'd0);
        check("rst_rails", x_top | x_bar_top | k_top | k_bar_top, 64'd0);
        #10 rst_n = 1'b1;
        tick();

        // Transaction 1: latency and rail timing.
        in_x = X1; in_k = K1; in_valid = 1'b1;
        check("t1_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0; in_x = '1; in_k = '1;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            if (cyc >= 3 && cyc <= 8) begin
                check("t1_xbar", x_bar_top, 64'h0000_0000_FFFF_FFFF);
                check("t1_kbar", k_bar_top, ~K1);
                check("t1_xtrue", x_top, X1);
            end else begin
                check("t1_rails0", x_top | x_bar_top | k_top | k_bar_top, 64'd0);
            end
            check("t1_valid", 64'(out_valid), (cyc == 9) ? 64'd1 : 64'd0);
            check("t1_in_ready_busy", 64'(in_ready), 64'd0);
            if (cyc < 9) tick();
        end
        check("t1_s", out_s, 64'hFEDC_BA98_89AB_CDEF);
        check("t1_unstable", 64'(out_unstable), 64'd0);

        // Back-pressure: out_ready low for cycles 9..13, a request offered meanwhile.
        in_valid = 1'b1; in_x = 64'h5555; in_k = 64'hAAAA;
        hold_s = out_s;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_s", out_s, hold_s);
            check("bp_unstable", 64'(out_unstable), 64'd0);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            tick();
        end
        in_valid = 1'b0;
        check("bp_valid6", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_retired", 64'(out_valid), 64'd0);
        check("bp_in_ready_after", 64'(in_ready), 64'd1);
        check("bp_busy_after", 64'(busy), 64'd0);

        // Unstable lane: bit 0 toggles between the two samples.
        run_unstable(64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F, 16'd1);
        run_unstable(64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F, 16'd2);

        // Back-to-back with out_ready tied high and in_valid held.
        out_ready = 1'b1;
        in_x = 64'hDEAD_BEEF_0000_1111; in_k = 64'h0000_FFFF_1234_0000; in_valid = 1'b1;
        tick();                          // accept A; cycle 1
        in_x = 64'hCAFE_F00D_AAAA_5555; in_k = 64'h1111_2222_3333_4444;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            check("b2b_not_accepted", 64'(in_ready), 64'd0);
            if (cyc < 9) tick();
        end
        check("b2b_a_valid", 64'(out_valid), 64'd1);
        check("b2b_a_s", out_s, 64'hDEAD_BEEF_0000_1111 ^ 64'h0000_FFFF_1234_0000);
        tick();                          // retired A; IDLE for exactly one cycle
        check("b2b_gap_ready", 64'(in_ready), 64'd1);
        check("b2b_gap_valid", 64'(out_valid), 64'd0);
        tick();                          // accept B
        in_valid = 1'b0;
        check("b2b_b_busy", 64'(busy), 64'd1);
        repeat (8) tick();
        check("b2b_b_valid", 64'(out_valid), 64'd1);
        check("b2b_b_s", out_s, 64'hCAFE_F00D_AAAA_5555 ^ 64'h1111_2222_3333_4444);
        tick();
        out_ready = 1'b0;
        check("b2b_b_retired", 64'(out_valid), 64'd0);

        // Short build: out_valid first high in cycle 5.
        in2_x = 64'h0123_4567_89AB_CDEF; in2_k = 64'hFFFF_0000_FFFF_0000; in2_valid = 1'b1;
        tick();
        in2_valid = 1'b0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            check("p11_valid", 64'(out2_valid), (cyc == 5) ? 64'd1 : 64'd0);
            if (cyc < 5) tick();
        end
        check("p11_s", out2_s, 64'h0123_4567_89AB_CDEF ^ 64'hFFFF_0000_FFFF_0000);
        check("p11_unstable", 64'(out2_unstable), 64'd0);
        check("p11_rails0", x2_bar_top | k2_bar_top | 64'(busy2 ^ 1'b1), 64'd0);
        check("p11_err", 64'(err2_count), 64'd0);
        out2_ready = 1'b1;
        tick();
        out2_ready = 1'b0;
        check("p11_retired", 64'(in2_ready), 64'd1);

        // Asynchronous reset in the middle of EVAL.
        in_x = X1; in_k = K1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();               // cycle 4: EVAL
        check("mid_eval_rails", x_bar_top, 64'h0000_0000_FFFF_FFFF);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_rails", x_top | x_bar_top | k_top | k_bar_top, 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_err", 64'(err_count), 64'd0);
        #4 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("post_rst_no_valid", 64'(out_valid), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cmos_lane_driver.md
Name: cmos_lane_driver

Overview:
- Host-side sequencer for the 64-bit dual-rail CMOS evaluation lane.
- Accepts an operand word x and key word k over a valid/ready handshake.
- Drives the complementary rails (x, x_bar, k, k_bar) with a return-to-zero spacer phase, then an evaluation phase.
- Samples the lane's s output twice, checks that it was stable, and returns the result over a second valid/ready handshake.

Parameters:
- BIT_SIZE, 64, lane width in bits; matches the lane.
- SPACER_CYCLES, 2, cycles all rails are held low before evaluation; legal range 1..255.
- SETTLE_CYCLES, 4, cycles the data rails are held before the first sample; legal range 1..255.
- CNT_W, 8, phase counter width; must hold max(SPACER_CYCLES, SETTLE_CYCLES).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request word present.
- in_ready  output  1  driver can accept a request.
- in_x  input  BIT_SIZE  operand word.
- in_k  input  BIT_SIZE  key word.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_s  output  BIT_SIZE  captured lane result.
- out_unstable  output  1  the two samples of s disagreed.
- x_top  output  BIT_SIZE  true rail of x to the lane.
- x_bar_top  output  BIT_SIZE  complement rail of x.
- k_top  output  BIT_SIZE  true rail of k.
- k_bar_top  output  BIT_SIZE  complement rail of k.
- s_top  input  BIT_SIZE  lane result.
- busy  output  1  high in any state other than IDLE.
- err_count  output  16  saturating count of unstable results.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE; all four rail buses = 0 (spacer).
  - out_valid = 0, out_s = 0, out_unstable = 0, err_count = 0, busy = 0.
  - Phase counter and operand registers cleared.
  - Deassertion takes effect on the next rising clk edge.
- Rail rule:
  - In IDLE, SPACER, DONE: x_top = x_bar_top = k_top = k_bar_top = 0.
  - In EVAL, SAMPLE_A, SAMPLE_B: x_top = x_reg, x_bar_top = ~x_reg, k_top = k_reg, k_bar_top = ~k_reg.
  - All rails are registered outputs, glitch-free.
  - A rail pair is never driven 1/1.
- State machine: IDLE -> SPACER -> EVAL -> SAMPLE_A -> SAMPLE_B -> DONE -> IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch in_x into x_reg and in_k into k_reg, load counter, go to SPACER.
- SPACER: hold exactly SPACER_CYCLES cycles, then EVAL.
- EVAL: hold exactly SETTLE_CYCLES cycles, then SAMPLE_A.
- SAMPLE_A: register s_top into samp_a; next state SAMPLE_B.
- SAMPLE_B:
  - Register s_top into out_s.
  - Set out_unstable = (samp_a != s_top).
  - If unstable and err_count != 16'hFFFF, increment err_count.
  - Next state DONE.
- DONE:
  - out_valid = 1; out_s and out_unstable held constant while out_valid & !out_ready.
  - On out_ready: out_valid drops next cycle, go to IDLE.
- Latency: with the accept edge as cycle 0, out_valid first rises in cycle SPACER_CYCLES + SETTLE_CYCLES + 3. Defaults give cycle 9.
- Handshakes:
  - in_ready is 0 in every state except IDLE.
  - in_x and in_k are ignored unless accepted.
  - No request is accepted in the same cycle a result is retired. Minimum back-to-back spacing is latency + 1 cycles.
- out_ready held high before DONE has no effect. out_valid never asserts without a completed SAMPLE_B.
- in_valid may drop without acceptance; no state change results.
- Reset mid-operation: the transaction is discarded, no out_valid, rails return to spacer immediately (asynchronously).
- err_count saturates at 16'hFFFF and clears only on reset.
- s_top is treated as quasi-static during the sample window. No extra synchronizer is required; the double sample is the stability check.

Test Plan:
- Reset with rails observed mid-EVAL -> all rails 0 asynchronously, busy = 0, out_valid = 0, err_count = 0.
- Lane model s = x ^ k with 2-cycle delay, in_x = 64'hFFFF_FFFF_0000_0000, in_k = 64'h0123_4567_89AB_CDEF -> out_valid at cycle 9, out_s = 64'hFEDC_BA98_89AB_CDEF, out_unstable = 0.
- Rails check on the same transaction:
  - cycles 1-2: all rails 0.
  - cycles 3-8: x_bar_top = 64'h0000_0000_FFFF_FFFF and k_bar_top = ~in_k.
  - cycle 9: rails 0 again.
- out_ready held low for 5 cycles after out_valid -> out_valid, out_s, out_unstable constant; in_ready stays 0; retirement on the 6th cycle, in_ready = 1 the following cycle.
- Lane model toggles bit 0 between SAMPLE_A and SAMPLE_B -> out_unstable = 1, err_count = 1; a second identical run gives err_count = 2.
- Two requests back-to-back with out_ready tied high:
  - Second accepted exactly one cycle after the first result retires.
  - Requests offered while busy are not accepted.
  - SPACER_CYCLES = 1, SETTLE_CYCLES = 1 build -> out_valid at cycle 5.
